// File: rtl/huffman_decoder.sv
// Serial Huffman decoder: 8-entry host-loaded code table, one symbol per complete codeword.
// Optional macro HUFF_DEC_ERR_EN: overlong codes stop the run in ERR instead of being discarded.
module huffman_decoder (
    input  logic       clk,
    input  logic       rst,
    input  logic       load_we,
    input  logic [2:0] load_addr,
    input  logic [7:0] load_sym,
    input  logic [2:0] load_len,
    input  logic [7:0] load_code,
    input  logic       start,
    input  logic [5:0] nsym,
    input  logic       bit_valid,
    input  logic       bit_in,
    output logic       bit_ready,
    output logic       sym_valid,
    input  logic       sym_ready,
    output logic [7:0] sym_out,
    output logic [5:0] sym_count,
    output logic       busy,
    output logic       done,
    output logic       err
);

`ifdef HUFF_DEC_ERR_EN
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_EMIT, S_ERR} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_EMIT} state_t;
`endif

    state_t     r_state, w_next;
    logic [7:0] r_sym  [8];
    logic [2:0] r_len  [8];
    logic [7:0] r_code [8];
    logic [6:0] r_acc;
    logic [2:0] r_n;
    logic [5:0] r_nsym;
    logic [5:0] r_count;
    logic [7:0] r_sym_out;

    logic [6:0] w_acc_n;
    logic [2:0] w_n_n;
    logic       w_accept;
    logic       w_hit;
    logic [7:0] w_hit_sym;
    logic       w_overlong;
    logic       w_start_ok;
    logic       w_emit_hs;
    logic       w_last;

    function automatic logic [7:0] len_mask(input logic [2:0] len);
        return (8'd1 << len) - 8'd1;
    endfunction

    assign bit_ready = (r_state == S_RUN) && (r_nsym != '0);
    assign sym_valid = (r_state == S_EMIT);
    assign sym_out   = r_sym_out;
    assign sym_count = r_count;
    assign busy      = (r_state == S_RUN) || (r_state == S_EMIT);
    assign done      = !busy;
`ifdef HUFF_DEC_ERR_EN
    assign err        = (r_state == S_ERR);
    assign w_start_ok = start && ((r_state == S_IDLE) || (r_state == S_ERR));
`else
    assign err        = 1'b0;
    assign w_start_ok = start && (r_state == S_IDLE);
`endif

    assign w_accept   = bit_valid && bit_ready;
    assign w_acc_n    = {r_acc[5:0], bit_in};
    assign w_n_n      = r_n + 3'd1;
    assign w_overlong = !w_hit && (w_n_n == 3'd7);
    assign w_emit_hs  = sym_valid && sym_ready;
    assign w_last     = (r_count + 6'd1) == r_nsym;

    // Ascending scan with a found guard so the lowest matching index wins.
    always_comb begin
        w_hit     = 1'b0;
        w_hit_sym = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            if (!w_hit && r_len[i] != '0 && r_len[i] == w_n_n &&
                ((r_code[i] ^ {1'b0, w_acc_n}) & len_mask(r_len[i])) == '0) begin
                w_hit     = 1'b1;
                w_hit_sym = r_sym[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (start) w_next = S_RUN;
            S_RUN: begin
                if (r_nsym == '0) begin
                    w_next = S_IDLE;
                end else if (w_accept) begin
                    if (w_hit) w_next = S_EMIT;
`ifdef HUFF_DEC_ERR_EN
                    else if (w_overlong) w_next = S_ERR;
`endif
                end
            end
            S_EMIT: if (sym_ready) w_next = w_last ? S_IDLE : S_RUN;
`ifdef HUFF_DEC_ERR_EN
            S_ERR: if (start) w_next = S_RUN;
`endif
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < 8; i++) r_len[i] <= '0;
            r_acc     <= '0;
            r_n       <= '0;
            r_nsym    <= '0;
            r_count   <= '0;
            r_sym_out <= '0;
        end else begin
            if (r_state == S_IDLE && load_we) begin
                r_sym[load_addr]  <= load_sym;
                r_len[load_addr]  <= load_len;
                r_code[load_addr] <= load_code;
            end
            if (w_start_ok) begin
                r_nsym  <= nsym;
                r_count <= '0;
                r_acc   <= '0;
                r_n     <= '0;
            end
            if (w_accept) begin
                if (w_hit || w_overlong) begin
                    r_acc <= '0;
                    r_n   <= '0;
                end else begin
                    r_acc <= w_acc_n;
                    r_n   <= w_n_n;
                end
                if (w_hit) r_sym_out <= w_hit_sym;
            end
            if (w_emit_hs) r_count <= r_count + 6'd1;
        end
    end

endmodule

// File: tb/tb_huffman_decoder.sv
// Directed bench for huffman_decoder; expected symbols and flags are hand-derived from the code table.
// Overlong-code expectations follow HUFF_DEC_ERR_EN when the bench is built with it.
module tb_huffman_decoder;

    logic       clk = 1'b0;
    logic       rst;
    logic       load_we;
    logic [2:0] load_addr;
    logic [7:0] load_sym;
    logic [2:0] load_len;
    logic [7:0] load_code;
    logic       start;
    logic [5:0] nsym;
    logic       bit_valid;
    logic       bit_in;
    logic       bit_ready;
    logic       sym_valid;
    logic       sym_ready;
    logic [7:0] sym_out;
    logic [5:0] sym_count;
    logic       busy;
    logic       done;
    logic       err;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    logic [7:0]  q[$];
    logic        saw_valid = 1'b0;

    huffman_decoder dut (
        .clk(clk), .rst(rst), .load_we(load_we), .load_addr(load_addr),
        .load_sym(load_sym), .load_len(load_len), .load_code(load_code),
        .start(start), .nsym(nsym), .bit_valid(bit_valid), .bit_in(bit_in),
        .bit_ready(bit_ready), .sym_valid(sym_valid), .sym_ready(sym_ready),
        .sym_out(sym_out), .sym_count(sym_count), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (sym_valid) saw_valid = 1'b1;
        if (sym_valid && sym_ready) q.push_back(sym_out);
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic load_entry(input logic [2:0] a, input logic [7:0] s,
                              input logic [2:0] l, input logic [7:0] c);
        load_we = 1'b1; load_addr = a; load_sym = s; load_len = l; load_code = c;
        tick();
        load_we = 1'b0;
    endtask

    task automatic load_basic();
        load_entry(3'd0, 8'h41, 3'd1, 8'b1);
        load_entry(3'd1, 8'h42, 3'd2, 8'b01);
        load_entry(3'd2, 8'h43, 3'd3, 8'b001);
        load_entry(3'd3, 8'h44, 3'd3, 8'b000);
    endtask

    task automatic start_run(input logic [5:0] n);
        start = 1'b1; nsym = n;
        tick();
        start = 1'b0;
    endtask

    task automatic send_bit(input logic b);
        logic ok;
        ok = 1'b0;
        bit_valid = 1'b1; bit_in = b;
        for (int k = 0; k < 50 && !ok; k++) begin
            if (bit_ready) ok = 1'b1;
            tick();
        end
        bit_valid = 1'b0;
        if (!ok) check_val("bit_accept_timeout", {31'd0, ok}, 32'd1);
    endtask

    task automatic wait_done(input string tag);
        for (int k = 0; k < 100 && !done; k++) tick();
        check_val(tag, {31'd0, done}, 32'd1);
    endtask

    task automatic check_q(input string tag, input int idx, input logic [7:0] exp);
        logic [31:0] got;
        got = (idx < q.size()) ? {24'd0, q[idx]} : 32'hdead;
        check_val(tag, got, {24'd0, exp});
    endtask

    initial begin
        rst = 1'b1; load_we = 1'b0; load_addr = '0; load_sym = '0; load_len = '0;
        load_code = '0; start = 1'b0; nsym = '0; bit_valid = 1'b0; bit_in = 1'b0;
        sym_ready = 1'b1;
        do_reset();

        check_val("rst_bit_ready", {31'd0, bit_ready}, 32'd0);
        check_val("rst_sym_valid", {31'd0, sym_valid}, 32'd0);
        check_val("rst_sym_out",   {24'd0, sym_out},   32'd0);
        check_val("rst_sym_count", {26'd0, sym_count}, 32'd0);
        check_val("rst_busy",      {31'd0, busy},      32'd0);
        check_val("rst_done",      {31'd0, done},      32'd1);
        check_val("rst_err",       {31'd0, err},       32'd0);

        // Basic decode: 1 | 01 | 001 | 000
        load_basic();
        start_run(6'd4);
        check_val("run_done_low", {31'd0, done}, 32'd0);
        check_val("run_busy",     {31'd0, busy}, 32'd1);
        q.delete();
        send_bit(1'b1);
        check_val("lat_sym_valid", {31'd0, sym_valid}, 32'd1);
        check_val("lat_bit_ready", {31'd0, bit_ready}, 32'd0);
        send_bit(1'b0); send_bit(1'b1);
        send_bit(1'b0); send_bit(1'b0); send_bit(1'b1);
        send_bit(1'b0); send_bit(1'b0); send_bit(1'b0);
        wait_done("basic_done");
        check_q("basic_s0", 0, 8'h41);
        check_q("basic_s1", 1, 8'h42);
        check_q("basic_s2", 2, 8'h43);
        check_q("basic_s3", 3, 8'h44);
        check_val("basic_nq",    q.size(),            32'd4);
        check_val("basic_count", {26'd0, sym_count},  32'd4);
        check_val("basic_busy",  {31'd0, busy},       32'd0);

        // Backpressure on the second symbol
        start_run(6'd4);
        q.delete();
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        sym_ready = 1'b0;
        bit_valid = 1'b1; bit_in = 1'b0;
        for (int c = 0; c < 5; c++) begin
            check_val("bp_valid",     {31'd0, sym_valid}, 32'd1);
            check_val("bp_sym",       {24'd0, sym_out},   32'h42);
            check_val("bp_bit_ready", {31'd0, bit_ready}, 32'd0);
            tick();
        end
        sym_ready = 1'b1;
        bit_valid = 1'b0;
        send_bit(1'b0); send_bit(1'b0); send_bit(1'b1);
        send_bit(1'b0); send_bit(1'b0); send_bit(1'b0);
        wait_done("bp_done");
        check_q("bp_s0", 0, 8'h41);
        check_q("bp_s1", 1, 8'h42);
        check_q("bp_s2", 2, 8'h43);
        check_q("bp_s3", 3, 8'h44);
        check_val("bp_nq", q.size(), 32'd4);

        // Overlong code
        do_reset();
        load_entry(3'd0, 8'h55, 3'd3, 8'b111);
        start_run(6'd1);
        q.delete();
        for (int b = 0; b < 7; b++) send_bit(1'b0);
`ifdef HUFF_DEC_ERR_EN
        check_val("ovl_err",       {31'd0, err},       32'd1);
        check_val("ovl_done",      {31'd0, done},      32'd1);
        check_val("ovl_bit_ready", {31'd0, bit_ready}, 32'd0);
        check_val("ovl_busy",      {31'd0, busy},      32'd0);
        start_run(6'd1);
        check_val("ovl_err_clr",   {31'd0, err},       32'd0);
        check_val("ovl_restart",   {31'd0, busy},      32'd1);
        send_bit(1'b1); send_bit(1'b1); send_bit(1'b1);
        wait_done("ovl_rerun_done");
        check_q("ovl_rerun_sym", 0, 8'h55);
`else
        check_val("ovl_nq0",       q.size(),           32'd0);
        check_val("ovl_sym_valid", {31'd0, sym_valid}, 32'd0);
        check_val("ovl_still_run", {31'd0, busy},      32'd1);
        send_bit(1'b1); send_bit(1'b1); send_bit(1'b1);
        wait_done("ovl_done");
        check_q("ovl_sym", 0, 8'h55);
        check_val("ovl_nq1", q.size(), 32'd1);
        check_val("ovl_err", {31'd0, err}, 32'd0);
`endif

        // Zero count
        do_reset();
        start_run(6'd0);
        check_val("zero_done_low",  {31'd0, done},      32'd0);
        check_val("zero_bit_ready", {31'd0, bit_ready}, 32'd0);
        tick();
        check_val("zero_done",      {31'd0, done},      32'd1);
        check_val("zero_bit_ready2",{31'd0, bit_ready}, 32'd0);

        // Write lockout during RUN
        load_basic();
        start_run(6'd1);
        q.delete();
        load_entry(3'd0, 8'h99, 3'd1, 8'b1);
        send_bit(1'b1);
        wait_done("lock_done");
        check_q("lock_sym", 0, 8'h41);

        // Reset mid-run after 2 bits of a 3-bit code
        start_run(6'd1);
        q.delete();
        saw_valid = 1'b0;
        send_bit(1'b0); send_bit(1'b0);
        do_reset();
        check_val("mrst_bit_ready", {31'd0, bit_ready}, 32'd0);
        check_val("mrst_sym_valid", {31'd0, sym_valid}, 32'd0);
        check_val("mrst_sym_out",   {24'd0, sym_out},   32'd0);
        check_val("mrst_sym_count", {26'd0, sym_count}, 32'd0);
        check_val("mrst_busy",      {31'd0, busy},      32'd0);
        check_val("mrst_done",      {31'd0, done},      32'd1);
        check_val("mrst_err",       {31'd0, err},       32'd0);
        check_val("mrst_no_valid",  {31'd0, saw_valid}, 32'd0);
        // Table is cleared: a single bit must not decode
        start_run(6'd1);
        send_bit(1'b1);
        tick(); tick();
        check_val("mrst_tbl_clear", q.size(), 32'd0);
        check_val("mrst_tbl_busy",  {31'd0, busy}, 32'd1);
        do_reset();
        load_basic();
        start_run(6'd2);
        send_bit(1'b0); send_bit(1'b0); send_bit(1'b1);
        send_bit(1'b1);
        wait_done("mrst_rerun_done");
        check_q("mrst_s0", 0, 8'h43);
        check_q("mrst_s1", 1, 8'h41);
        check_val("mrst_count", {26'd0, sym_count}, 32'd2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
